// File: rtl/time_set_editor_pkg.sv
// Shared constants and helpers for the time/date setting editor:
// one-hot field selects, field widths and ranges, month length and wrap stepping.
package time_set_editor_pkg;

    localparam int SEL_W  = 7;
    localparam int MON_W  = 4;
    localparam int DAY_W  = 5;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int WDAY_W = 3;

    localparam logic [SEL_W-1:0] SEL_L1 = 7'b0000001;
    localparam logic [SEL_W-1:0] SEL_L2 = 7'b0000010;
    localparam logic [SEL_W-1:0] SEL_L3 = 7'b0000100;
    localparam logic [SEL_W-1:0] SEL_L4 = 7'b0001000;
    localparam logic [SEL_W-1:0] SEL_L5 = 7'b0010000;
    localparam logic [SEL_W-1:0] SEL_L6 = 7'b0100000;
    localparam logic [SEL_W-1:0] SEL_L7 = 7'b1000000;

    // Ranges are 6 bits wide so every field can share one stepping helper.
    localparam logic [5:0] MON_LO  = 6'd1;
    localparam logic [5:0] MON_HI  = 6'd12;
    localparam logic [5:0] DAY_LO  = 6'd1;
    localparam logic [5:0] HOUR_LO = 6'd0;
    localparam logic [5:0] HOUR_HI = 6'd23;
    localparam logic [5:0] MIN_LO  = 6'd0;
    localparam logic [5:0] MIN_HI  = 6'd59;
    localparam logic [5:0] SEC_LO  = 6'd0;
    localparam logic [5:0] SEC_HI  = 6'd59;
    localparam logic [5:0] WDAY_LO = 6'd0;
    localparam logic [5:0] WDAY_HI = 6'd6;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_EDIT = 1'b1
    } edit_state_e;

    // February is always 28: the calendar has no leap-year support.
    function automatic logic [DAY_W-1:0] month_len(input logic [MON_W-1:0] mon);
        case (mon)
            4'd2:                      return 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [SEL_W-1:0] s);
        return (s != '0) && ((s & (s - 7'd1)) == '0);
    endfunction

    function automatic logic [5:0] step_wrap(input logic [5:0] val, input logic [5:0] lo,
                                             input logic [5:0] hi, input logic up);
        if (up) return (val >= hi) ? lo : val + 6'd1;
        else    return (val <= lo) ? hi : val - 6'd1;
    endfunction

endpackage

// File: rtl/time_set_editor_btn_repeat.sv
// Button edge detect with hold-to-repeat: one step on press, then after REP_DELAY
// ticks one step every REP_RATE ticks. clr_i disarms until the button is re-pressed.
module time_set_editor_btn_repeat #(
    parameter int REP_DELAY = 500,
    parameter int REP_RATE  = 100
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    input  logic tick_i,
    input  logic clr_i,
    output logic step_o
);

    localparam int CNT_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             prev_q;
    logic             armed_q, armed_d;
    logic             rep_q, rep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
        step_o  = 1'b0;
        armed_d = armed_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CNT_W'(1);
        if (clr_i || !btn_i) begin
            armed_d = 1'b0;
            rep_d   = 1'b0;
            cnt_d   = '0;
        end else if (!prev_q) begin
            step_o  = 1'b1;
            armed_d = 1'b1;
            rep_d   = 1'b0;
            cnt_d   = '0;
        end else if (armed_q && tick_i) begin
            // First threshold is the initial delay, afterwards the repeat period.
            if (cnt_inc == (rep_q ? CNT_W'(REP_RATE) : CNT_W'(REP_DELAY))) begin
                step_o = 1'b1;
                rep_d  = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            rep_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            prev_q  <= btn_i;
            armed_q <= armed_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/time_set_editor.sv
// Time/date setting editor: captures running time on entering edit, steps the selected
// field with UP/DOWN auto-repeat, blinks the edited field and strobes LOAD on exit.
module time_set_editor
    import time_set_editor_pkg::*;
#(
    parameter int REP_DELAY  = 500,
    parameter int REP_RATE   = 100,
    parameter int BLINK_HALF = 250
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              up_i,
    input  logic              down_i,
    input  logic              tick_ms_i,
    input  logic [MON_W-1:0]  cur_mon_i,
    input  logic [DAY_W-1:0]  cur_day_i,
    input  logic [HOUR_W-1:0] cur_hour_i,
    input  logic [MIN_W-1:0]  cur_min_i,
    input  logic [SEC_W-1:0]  cur_sec_i,
    input  logic [WDAY_W-1:0] cur_wday_i,
    output logic [MON_W-1:0]  set_mon_o,
    output logic [DAY_W-1:0]  set_day_o,
    output logic [HOUR_W-1:0] set_hour_o,
    output logic [MIN_W-1:0]  set_min_o,
    output logic [SEC_W-1:0]  set_sec_o,
    output logic [WDAY_W-1:0] set_wday_o,
    output logic              load_o,
    output logic [SEL_W-1:0]  blank_o,
    output edit_state_e       state_o
);

    localparam int BW = $clog2(BLINK_HALF + 1);

    edit_state_e       state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_dec, blank_q, blank_d;
    logic [MON_W-1:0]  mon_q, mon_d;
    logic [DAY_W-1:0]  day_q, day_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [WDAY_W-1:0] wday_q, wday_d;
    logic              load_q, load_d;
    logic              phase_q, phase_d;
    logic [BW-1:0]     blink_q, blink_d;
    logic              sel_chg, btn_clr, up_step, dn_step;

    assign sel_dec = is_onehot(sel_i) ? sel_i : SEL_L1;
    assign sel_chg = (sel_dec != sel_q);
    // Any select change disarms both buttons so a held key must be re-pressed.
    assign btn_clr = (state_q != ST_EDIT) || sel_chg || (up_i && down_i);

    time_set_editor_btn_repeat #(.REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_up (
        .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(up_i), .tick_i(tick_ms_i),
        .clr_i(btn_clr), .step_o(up_step)
    );

    time_set_editor_btn_repeat #(.REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_dn (
        .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(down_i), .tick_i(tick_ms_i),
        .clr_i(btn_clr), .step_o(dn_step)
    );

    always_comb begin
        state_d = state_q;
        mon_d   = mon_q;
        day_d   = day_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        wday_d  = wday_q;
        load_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (sel_dec != SEL_L1) begin
                    state_d = ST_EDIT;
                    mon_d   = cur_mon_i;
                    day_d   = (cur_day_i > month_len(cur_mon_i)) ? month_len(cur_mon_i) : cur_day_i;
                    hour_d  = cur_hour_i;
                    min_d   = cur_min_i;
                    sec_d   = cur_sec_i;
                    wday_d  = cur_wday_i;
                end
            end
            ST_EDIT: begin
                if (sel_dec == SEL_L1) begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end else if (up_step || dn_step) begin
                    case (sel_dec)
                        SEL_L2: begin
                            mon_d = MON_W'(step_wrap(6'(mon_q), MON_LO, MON_HI, up_step));
                            if (day_q > month_len(mon_d)) day_d = month_len(mon_d);
                        end
                        SEL_L3: day_d  = DAY_W'(step_wrap(6'(day_q), DAY_LO, 6'(month_len(mon_q)), up_step));
                        SEL_L4: hour_d = HOUR_W'(step_wrap(6'(hour_q), HOUR_LO, HOUR_HI, up_step));
                        SEL_L5: min_d  = MIN_W'(step_wrap(min_q, MIN_LO, MIN_HI, up_step));
                        SEL_L6: sec_d  = SEC_W'(step_wrap(sec_q, SEC_LO, SEC_HI, up_step));
                        SEL_L7: wday_d = WDAY_W'(step_wrap(6'(wday_q), WDAY_LO, WDAY_HI, up_step));
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Blink restarts in the visible phase whenever the user touches the field.
    always_comb begin
        phase_d = phase_q;
        blink_d = blink_q;
        if ((state_d != ST_EDIT) || up_step || dn_step || sel_chg) begin
            phase_d = 1'b0;
            blink_d = '0;
        end else if (tick_ms_i) begin
            if (blink_q + BW'(1) == BW'(BLINK_HALF)) begin
                phase_d = ~phase_q;
                blink_d = '0;
            end else begin
                blink_d = blink_q + BW'(1);
            end
        end
        blank_d = ((state_d == ST_EDIT) && phase_d) ? sel_dec : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            sel_q   <= SEL_L1;
            mon_q   <= MON_W'(1);
            day_q   <= DAY_W'(1);
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            wday_q  <= '0;
            load_q  <= 1'b0;
            phase_q <= 1'b0;
            blink_q <= '0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_dec;
            mon_q   <= mon_d;
            day_q   <= day_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            wday_q  <= wday_d;
            load_q  <= load_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
            blank_q <= blank_d;
        end
    end

    assign set_mon_o  = mon_q;
    assign set_day_o  = day_q;
    assign set_hour_o = hour_q;
    assign set_min_o  = min_q;
    assign set_sec_o  = sec_q;
    assign set_wday_o = wday_q;
    assign load_o     = load_q;
    assign blank_o    = blank_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_time_set_editor.sv
// Bench for time_set_editor: directed button/select sequences, a cycle-level
// reference model compared every cycle, and literal checkpoints along the way.
module tb_time_set_editor;
    import time_set_editor_pkg::*;

    localparam int RD = 5;
    localparam int RR = 2;
    localparam int BH = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] sel;
    logic       up, down, tick_ms;
    logic [3:0] cur_mon;
    logic [4:0] cur_day, cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic [2:0] cur_wday;
    logic [3:0] set_mon;
    logic [4:0] set_day, set_hour;
    logic [5:0] set_min, set_sec;
    logic [2:0] set_wday;
    logic       load;
    logic [6:0] blank;
    edit_state_e state;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 0;

    time_set_editor #(.REP_DELAY(RD), .REP_RATE(RR), .BLINK_HALF(BH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .up_i(up), .down_i(down), .tick_ms_i(tick_ms),
        .cur_mon_i(cur_mon), .cur_day_i(cur_day), .cur_hour_i(cur_hour), .cur_min_i(cur_min),
        .cur_sec_i(cur_sec), .cur_wday_i(cur_wday),
        .set_mon_o(set_mon), .set_day_o(set_day), .set_hour_o(set_hour), .set_min_o(set_min),
        .set_sec_o(set_sec), .set_wday_o(set_wday), .load_o(load), .blank_o(blank), .state_o(state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int mlen [13] = '{31, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int m_mon = 1, m_day = 1, m_hour = 0, m_min = 0, m_sec = 0, m_wday = 0;
    int m_load = 0, m_blank = 0, m_sel = 1, m_bt = 0;
    bit m_edit = 0;
    bit m_prev [2];
    bit m_armed [2];
    int m_held [2];

    function automatic int ml(input int mon);
        return (mon >= 1 && mon <= 12) ? mlen[mon] : 31;
    endfunction

    function automatic bit btn_model(input int i, input bit lvl, input bit clr, input bit tk);
        bit s;
        s = 0;
        if (clr || !lvl) begin
            m_armed[i] = 0;
            m_held[i]  = 0;
        end else if (!m_prev[i]) begin
            s = 1;
            m_armed[i] = 1;
            m_held[i]  = 0;
        end else if (m_armed[i] && tk) begin
            m_held[i]++;
            s = (m_held[i] == RD) || (m_held[i] > RD && (m_held[i] - RD) % RR == 0);
        end
        m_prev[i] = lvl;
        return s;
    endfunction

    task automatic model_reset();
        m_mon = 1; m_day = 1; m_hour = 0; m_min = 0; m_sec = 0; m_wday = 0;
        m_load = 0; m_blank = 0; m_sel = 1; m_bt = 0; m_edit = 0;
        for (int i = 0; i < 2; i++) begin
            m_prev[i] = 0; m_armed[i] = 0; m_held[i] = 0;
        end
    endtask

    task automatic model_cycle();
        int sd, mx;
        bit was_edit, chg, us, ds;
        sd = ($countones(sel) == 1) ? int'(sel) : 1;
        was_edit = m_edit;
        chg = (sd != m_sel);
        us = btn_model(0, up, !was_edit || chg || (up && down), tick_ms);
        ds = btn_model(1, down, !was_edit || chg || (up && down), tick_ms);
        m_load = 0;
        if (!was_edit) begin
            if (sd != 1) begin
                m_edit = 1;
                m_mon = int'(cur_mon);
                m_day = (int'(cur_day) > ml(m_mon)) ? ml(m_mon) : int'(cur_day);
                m_hour = int'(cur_hour); m_min = int'(cur_min);
                m_sec = int'(cur_sec);   m_wday = int'(cur_wday);
            end
        end else if (sd == 1) begin
            m_edit = 0;
            m_load = 1;
        end else if (us || ds) begin
            case (sd)
                2: begin
                    m_mon = us ? m_mon % 12 + 1 : (m_mon + 10) % 12 + 1;
                    if (m_day > ml(m_mon)) m_day = ml(m_mon);
                end
                4: begin
                    mx = ml(m_mon);
                    m_day = us ? m_day % mx + 1 : (m_day + mx - 2) % mx + 1;
                end
                8:  m_hour = us ? (m_hour + 1) % 24 : (m_hour + 23) % 24;
                16: m_min  = us ? (m_min + 1) % 60 : (m_min + 59) % 60;
                32: m_sec  = us ? (m_sec + 1) % 60 : (m_sec + 59) % 60;
                64: m_wday = us ? (m_wday + 1) % 7 : (m_wday + 6) % 7;
                default: ;
            endcase
        end
        if (!m_edit || us || ds || chg) m_bt = 0;
        else if (tick_ms) m_bt++;
        m_blank = (m_edit && ((m_bt / BH) % 2 == 1)) ? sd : 0;
        m_sel = sd;
    endtask

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_cycle();
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_mon", 32'(set_mon), m_mon);
            check("m_day", 32'(set_day), m_day);
            check("m_hour", 32'(set_hour), m_hour);
            check("m_min", 32'(set_min), m_min);
            check("m_sec", 32'(set_sec), m_sec);
            check("m_wday", 32'(set_wday), m_wday);
            check("m_load", 32'(load), m_load);
            check("m_blank", 32'(blank), m_blank);
            check("m_state", 32'(state), 32'(m_edit));
        end
    end

    // ---------------- driver ----------------
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick_ms = 1'b1;
        clk1();
        tick_ms = 1'b0;
        clk1();
    endtask

    initial begin
        rst_n = 1'b0; sel = 7'b0000001; up = 1'b0; down = 1'b0; tick_ms = 1'b0;
        cur_mon = 4'd2; cur_day = 5'd30; cur_hour = 5'd10;
        cur_min = 6'd59; cur_sec = 6'd59; cur_wday = 3'd6;
        clk1();
        cmp_en = 1;
        clk1();
        rst_n = 1'b1;
        clk1();
        check("rst_mon", 32'(set_mon), 1);
        check("rst_day", 32'(set_day), 1);
        check("rst_hour", 32'(set_hour), 0);
        check("rst_load", 32'(load), 0);
        check("rst_blank", 32'(blank), 0);

        // capture with day clamp, then exit with LOAD pulse
        sel = 7'b0000010; clk1();
        check("cap_mon", 32'(set_mon), 2);
        check("cap_day", 32'(set_day), 28);
        check("cap_hour", 32'(set_hour), 10);
        check("cap_wday", 32'(set_wday), 6);
        sel = 7'b0000001; clk1();
        check("load_hi", 32'(load), 1);
        clk1();
        check("load_lo", 32'(load), 0);

        // minute wrap both directions
        sel = 7'b0010000; clk1();
        check("min_cap", 32'(set_min), 59);
        up = 1'b1; clk1();
        check("min_up_wrap", 32'(set_min), 0);
        up = 1'b0; clk1();
        down = 1'b1; clk1();
        check("min_dn_wrap", 32'(set_min), 59);
        down = 1'b0; clk1();

        // hour auto-repeat
        sel = 7'b0001000; clk1();
        up = 1'b1; clk1();
        check("rep_press", 32'(set_hour), 11);
        for (int t = 1; t <= 10; t++) begin
            do_tick();
            check("rep_hour", 32'(set_hour), 11 + (t >= 5) + (t >= 7) + (t >= 9));
        end
        up = 1'b0; clk1();
        do_tick(); do_tick();
        check("rel_hour", 32'(set_hour), 14);

        // month step with day clamp, both buttons, blink
        sel = 7'b0000001; cur_mon = 4'd1; cur_day = 5'd31; clk1(); clk1();
        sel = 7'b0000010; clk1();
        check("jan_mon", 32'(set_mon), 1);
        check("jan_day", 32'(set_day), 31);
        up = 1'b1; clk1();
        check("feb_mon", 32'(set_mon), 2);
        check("feb_day", 32'(set_day), 28);
        up = 1'b0; clk1();
        up = 1'b1; down = 1'b1; clk1(); clk1();
        check("both_mon", 32'(set_mon), 2);
        up = 1'b0; down = 1'b0; clk1();
        do_tick(); do_tick(); do_tick();
        check("blink_on", 32'(blank), 32'h02);
        do_tick(); do_tick(); do_tick();
        check("blink_off", 32'(blank), 0);
        down = 1'b1; clk1();
        check("mon_dn", 32'(set_mon), 1);
        down = 1'b0; clk1();

        // weekday and second wraps
        sel = 7'b1000000; clk1();
        up = 1'b1; clk1();
        check("wday_up", 32'(set_wday), 0);
        up = 1'b0; clk1();
        down = 1'b1; clk1();
        check("wday_dn", 32'(set_wday), 6);
        down = 1'b0; sel = 7'b0100000; clk1();
        up = 1'b1; clk1();
        check("sec_up", 32'(set_sec), 0);
        up = 1'b0; clk1();

        // invalid select exits edit; reset mid-edit
        sel = 7'b0000011; clk1();
        check("inv_load", 32'(load), 1);
        check("inv_blank", 32'(blank), 0);
        clk1();
        check("inv_load_lo", 32'(load), 0);
        sel = 7'b0000100; clk1();
        check("re_edit", 32'(state), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mon", 32'(set_mon), 1);
        check("mid_rst_min", 32'(set_min), 0);
        check("mid_rst_state", 32'(state), 0);
        clk1(); clk1();
        sel = 7'b0000001; clk1();
        rst_n = 1'b1; clk1();
        check("no_load", 32'(load), 0);
        clk1(); clk1();
        cmp_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/time_set_editor.md
Name: time_set_editor

Overview:
- Consumer of the 7-bit one-hot field-select code produced by the setting-mode sequencer (L1 = run/no edit, L2..L7 = editable fields).
- Captures the running time on entry to edit, applies UP/DOWN button edits with auto-repeat to the selected field, and drives per-field blink blanking.
- Issues a one-cycle LOAD strobe with the edited values when the select returns to L1.
- Sits between the setting-mode sequencer and the clock/calendar counters.

Parameters:
- REP_DELAY, 500, TICK_MS pulses a button must be held before auto-repeat starts
- REP_RATE, 100, TICK_MS pulses between auto-repeat steps
- BLINK_HALF, 250, TICK_MS pulses per blink half-period

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- SEL  in  7  one-hot field select: 0000001 = L1 run; 0000010 = L2 month; 0000100 = L3 day; 0001000 = L4 hour; 0010000 = L5 minute; 0100000 = L6 second; 1000000 = L7 weekday
- UP  in  1  debounced level, synchronous to CLK
- DOWN  in  1  debounced level, synchronous to CLK
- TICK_MS  in  1  single-cycle 1 ms enable pulse
- CUR_MON  in  4  running month, 1..12
- CUR_DAY  in  5  running day, 1..31
- CUR_HOUR  in  5  running hour, 0..23
- CUR_MIN  in  6  running minute, 0..59
- CUR_SEC  in  6  running second, 0..59
- CUR_WDAY  in  3  running weekday, 0..6
- SET_MON, SET_DAY, SET_HOUR, SET_MIN, SET_SEC, SET_WDAY  out  4/5/5/6/6/3  edited values
- LOAD  out  1  one-cycle strobe: SET_* valid, to be loaded into the counters
- BLANK  out  7  one-hot blanking mask for the display, same bit order as SEL

Behaviour:
- Reset (RESET_N = 0, asynchronous): SET_MON = 1, SET_DAY = 1, SET_HOUR/MIN/SEC/WDAY = 0, LOAD = 0, BLANK = 0. Repeat and blink counters cleared. Edit FSM goes to RUN.
- SEL decode: any value that is not exactly one-hot is treated as L1.
- Edit FSM states: RUN, EDIT.
  - RUN -> EDIT when decoded SEL ≠ L1. The CUR_* values are captured into SET_* in that same cycle; no edit is applied in the capture cycle.
  - EDIT -> RUN when decoded SEL = L1. LOAD = 1 for exactly the next cycle; SET_* hold their values.
  - While in RUN, SET_* track nothing and hold their last values.
- Button engine (EDIT only):
  - UP and DOWN are edge-detected with 1-cycle registers.
  - A rising edge applies one step, registered: the field updates one cycle after the edge.
  - While the button stays held, a hold counter counts TICK_MS pulses. After REP_DELAY pulses, one step is applied every REP_RATE pulses.
  - Release clears the hold counter.
  - UP and DOWN both high: no step, and the hold counter is cleared.
  - A change of SEL clears the hold counter; a held button must be re-pressed on the new field.
- Step arithmetic (wrap-around):
  - month 12 -> 1 on UP, 1 -> 12 on DOWN
  - hour 23 <-> 0
  - minute and second 59 <-> 0
  - weekday 6 <-> 0
  - day wraps between 1 and max(month): Feb = 28 (no leap), Apr/Jun/Sep/Nov = 30, others 31
- Day clamp: when the month changes, a day greater than the new max(month) is clamped to max in the same cycle as the month update. Captured CUR_DAY values are also clamped.
- Blink: a counter toggles phase every BLINK_HALF TICK_MS pulses.
  - BLANK = decoded SEL when in EDIT and phase = 1, else 0.
  - Phase is forced to 0 on any step and on any SEL change, so the field stays visible while it is being adjusted.
- Reset mid-edit: all state is lost and no LOAD is issued.

Decomposition:
- Shared package holds:
  - the one-hot SEL constants L1..L7
  - field width constants
  - field min/max constants
  - the month-length function
- One sub-module, btn_repeat: edge detect + hold/repeat counter. Instantiated twice (UP, DOWN). Output is a single-cycle step pulse.

Test Plan:
- Reset, then SEL = L1 -> SET_MON = 1, SET_DAY = 1, others 0; LOAD = 0; BLANK = 0.
- CUR = 02/30 10:59:59 wd 6; SEL L1 -> L2 -> SET_MON = 2, SET_DAY = 28 (clamped); SEL -> L1 -> LOAD high for exactly 1 cycle.
- SEL = L5, SET_MIN = 59, one UP edge -> SET_MIN = 0 the next cycle; one DOWN edge -> 59.
- SEL = L4, hold UP, REP_DELAY = 5, REP_RATE = 2 -> hour increments at press, then at tick 5, 7, 9; release stops increments.
- SEL = L2, SET_DAY = 31, month 1 -> UP -> SET_MON = 2, SET_DAY = 28; UP and DOWN both high -> no change.
- In EDIT, SEL = 0000011 (invalid) -> LOAD pulse, BLANK = 0; assert RESET_N low while in EDIT -> no LOAD, all outputs at reset values.
